// File: rtl/mem_read_responder.sv
// Memory-node read responder: filters incoming read requests into a small FIFO,
// reads the ifmap or filter store and returns a data packet to the requester.
module mem_read_responder #(
  parameter int WIDTH            = 5,
  parameter int VALID_DATA_WIDTH = 8,
  parameter int DATA_WIDTH       = 20,
  parameter int MEM_INDEX        = 0,
  parameter int IFMAP_DEPTH      = 64,
  parameter int FILTER_DEPTH     = 16,
  parameter int FIFO_DEPTH       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       pkt_in,
  input  logic                        pkt_in_valid,
  output logic                        pkt_in_ready,
  output logic [DATA_WIDTH-1:0]       pkt_out,
  output logic                        pkt_out_valid,
  input  logic                        pkt_out_ready,
  input  logic                        ld_en,
  input  logic                        ld_sel,
  input  logic [7:0]                  ld_addr,
  input  logic [VALID_DATA_WIDTH-1:0] ld_data,
  output logic                        busy,
  output logic [7:0]                  drop_cnt,
  output logic                        err_oor
);

  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam int IF_AW = $clog2(IFMAP_DEPTH);
  localparam int FL_AW = $clog2(FILTER_DEPTH);
  localparam int PW    = VALID_DATA_WIDTH;
  localparam int EW    = WIDTH + 2 + VALID_DATA_WIDTH;
  localparam logic [PW:0] IF_LIM    = (PW+1)'(IFMAP_DEPTH);
  localparam logic [PW:0] FL_LIM    = (PW+1)'(FILTER_DEPTH);
  localparam logic [8:0]  IF_LD_LIM = 9'(IFMAP_DEPTH);
  localparam logic [8:0]  FL_LD_LIM = 9'(FILTER_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_t;

  state_t state_q, state_d;

  logic [VALID_DATA_WIDTH-1:0] ifmap_mem_q  [IFMAP_DEPTH];
  logic [VALID_DATA_WIDTH-1:0] filter_mem_q [FILTER_DEPTH];
  logic [EW-1:0]               fifo_mem_q   [FIFO_DEPTH];

  logic [FA_W:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]            req_src_q, req_src_d;
  logic [1:0]                  req_type_q, req_type_d;
  logic [PW-1:0]               req_ptr_q, req_ptr_d;
  logic [VALID_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]       pkt_out_q, pkt_out_d;
  logic                        pkt_out_valid_q, pkt_out_valid_d;
  logic [7:0]                  drop_cnt_q, drop_cnt_d;
  logic                        err_oor_q, err_oor_d;

  logic fifo_empty, fifo_full, accept, admit, push, pop, read_oor, read_fire;
  logic [WIDTH-1:0]            in_dst;
  logic [1:0]                  in_type;
  logic [EW-1:0]               fifo_head;
  logic [VALID_DATA_WIDTH-1:0] store_word;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FA_W] != rd_ptr_q[FA_W]) &&
                      (wr_ptr_q[FA_W-1:0] == rd_ptr_q[FA_W-1:0]);
  assign fifo_head  = fifo_mem_q[rd_ptr_q[FA_W-1:0]];

  assign in_dst  = pkt_in[DATA_WIDTH-WIDTH-1 -: WIDTH];
  assign in_type = pkt_in[VALID_DATA_WIDTH+1 : VALID_DATA_WIDTH];
  assign accept  = pkt_in_valid && !fifo_full;
  assign admit   = (in_dst == WIDTH'(MEM_INDEX)) && ((in_type == 2'd1) || (in_type == 2'd2));
  assign push    = accept && admit;
  assign pop     = (state_q == S_IDLE) && !fifo_empty;

  // Load port owns the store for the cycle it writes, so a read stalls behind it.
  assign read_fire  = (state_q == S_READ) && !ld_en;
  assign read_oor   = (req_type_q == 2'd2) ? ({1'b0, req_ptr_q} >= FL_LIM)
                                           : ({1'b0, req_ptr_q} >= IF_LIM);
  assign store_word = (req_type_q == 2'd2) ? filter_mem_q[req_ptr_q[FL_AW-1:0]]
                                           : ifmap_mem_q[req_ptr_q[IF_AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_READ;
      S_READ:  if (!ld_en) state_d = S_RESP;
      S_RESP:  if (pkt_out_valid_q && pkt_out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d        = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d        = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    req_src_d       = req_src_q;
    req_type_d      = req_type_q;
    req_ptr_d       = req_ptr_q;
    rdata_d         = rdata_q;
    err_oor_d       = err_oor_q;
    pkt_out_d       = pkt_out_q;
    pkt_out_valid_d = pkt_out_valid_q;
    drop_cnt_d      = drop_cnt_q;
    if (accept && !admit && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    if (pop) {req_src_d, req_type_d, req_ptr_d} = fifo_head;
    if (read_fire) begin
      rdata_d = read_oor ? '0 : store_word;
      if (read_oor) err_oor_d = 1'b1;
    end
    if (state_q == S_RESP) begin
      if (!pkt_out_valid_q) begin
        pkt_out_valid_d = 1'b1;
        pkt_out_d       = {WIDTH'(MEM_INDEX), req_src_q, req_type_q, rdata_q};
      end else if (pkt_out_ready) begin
        pkt_out_valid_d = 1'b0;
        pkt_out_d       = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      req_src_q       <= '0;
      req_type_q      <= '0;
      req_ptr_q       <= '0;
      rdata_q         <= '0;
      err_oor_q       <= 1'b0;
      pkt_out_q       <= '0;
      pkt_out_valid_q <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      req_src_q       <= req_src_d;
      req_type_q      <= req_type_d;
      req_ptr_q       <= req_ptr_d;
      rdata_q         <= rdata_d;
      err_oor_q       <= err_oor_d;
      pkt_out_q       <= pkt_out_d;
      pkt_out_valid_q <= pkt_out_valid_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  // Storage arrays are not reset; store contents survive rst.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[FA_W-1:0]] <= {pkt_in[DATA_WIDTH-1 -: WIDTH], pkt_in[VALID_DATA_WIDTH+1:0]};
    if (ld_en && !ld_sel && ({1'b0, ld_addr} < IF_LD_LIM)) ifmap_mem_q[ld_addr[IF_AW-1:0]] <= ld_data;
    if (ld_en &&  ld_sel && ({1'b0, ld_addr} < FL_LD_LIM)) filter_mem_q[ld_addr[FL_AW-1:0]] <= ld_data;
  end

  assign pkt_in_ready  = !fifo_full;
  assign pkt_out       = pkt_out_q;
  assign pkt_out_valid = pkt_out_valid_q;
  assign busy          = !fifo_empty || (state_q != S_IDLE);
  assign drop_cnt      = drop_cnt_q;
  assign err_oor       = err_oor_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed, table-driven bench for mem_read_responder with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_read_responder;

  localparam int MI = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] pkt_in;
  logic        pkt_in_valid;
  logic        pkt_in_ready;
  logic [19:0] pkt_out;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic        ld_en;
  logic        ld_sel;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic        err_oor;

  mem_read_responder #(
    .WIDTH(5), .VALID_DATA_WIDTH(8), .DATA_WIDTH(20), .MEM_INDEX(MI),
    .IFMAP_DEPTH(64), .FILTER_DEPTH(16), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
    .pkt_out(pkt_out), .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .drop_cnt(drop_cnt), .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] src;
    logic [4:0] dst;
    logic [1:0] typ;
    logic [7:0] ptr;
    bit         resp;
    logic [7:0] data;
    logic [7:0] drops;
    bit         oor;
  } vec_t;

  vec_t vecs [12];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] mkpkt(input logic [4:0] s, input logic [4:0] d,
                                        input logic [1:0] t, input logic [7:0] v);
    return {s, d, t, v};
  endfunction

  task automatic load(input logic sel, input logic [7:0] addr, input logic [7:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int unsigned idx);
    int unsigned cyc;
    pkt_in = mkpkt(v.src, v.dst, v.typ, v.ptr);
    pkt_in_valid = 1'b1;
    chk($sformatf("vec%0d_in_ready", idx), 32'(pkt_in_ready), 32'd1);
    tick();
    pkt_in_valid = 1'b0;
    pkt_in = '0;
    if (!v.resp) chk($sformatf("vec%0d_drop_busy", idx), 32'(busy), 32'd0);
    cyc = 0;
    while (!pkt_out_valid && cyc < 8) begin
      tick();
      cyc++;
    end
    if (v.resp) begin
      chk($sformatf("vec%0d_latency", idx), cyc, 32'd3);
      chk($sformatf("vec%0d_pkt_out", idx), 32'(pkt_out), 32'({5'(MI), v.src, v.typ, v.data}));
      tick();
      chk($sformatf("vec%0d_valid_drop", idx), 32'(pkt_out_valid), 32'd0);
    end else begin
      chk($sformatf("vec%0d_no_resp", idx), 32'(pkt_out_valid), 32'd0);
    end
    chk($sformatf("vec%0d_drop_cnt", idx), 32'(drop_cnt), 32'(v.drops));
    chk($sformatf("vec%0d_err_oor", idx), 32'(err_oor), 32'(v.oor));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0]  first, exp_pkt;
    logic [19:0]  got [3];
    int unsigned  n, cyc;
    bit           stable, ready_low, seen;
    vec_t         rv;

    rst = 1'b1; pkt_in = '0; pkt_in_valid = 1'b0; pkt_out_ready = 1'b1;
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;

    // ifmap[i] = 3i+1 (ifmap[5] later overwritten with 0x2A), filter[i] = 0xA0+i
    vecs[0]  = '{5'd3,  5'd0, 2'd1, 8'd5,  1'b1, 8'h2A, 8'd0, 1'b0};
    vecs[1]  = '{5'd1,  5'd0, 2'd1, 8'd0,  1'b1, 8'h01, 8'd0, 1'b0};
    vecs[2]  = '{5'd7,  5'd0, 2'd1, 8'd63, 1'b1, 8'hBE, 8'd0, 1'b0};
    vecs[3]  = '{5'd2,  5'd0, 2'd2, 8'd0,  1'b1, 8'hA0, 8'd0, 1'b0};
    vecs[4]  = '{5'd31, 5'd0, 2'd2, 8'd15, 1'b1, 8'hAF, 8'd0, 1'b0};
    vecs[5]  = '{5'd4,  5'd1, 2'd1, 8'd5,  1'b0, 8'h00, 8'd1, 1'b0};
    vecs[6]  = '{5'd4,  5'd0, 2'd3, 8'd5,  1'b0, 8'h00, 8'd2, 1'b0};
    vecs[7]  = '{5'd4,  5'd0, 2'd0, 8'd5,  1'b0, 8'h00, 8'd3, 1'b0};
    vecs[8]  = '{5'd5,  5'd0, 2'd1, 8'd64, 1'b1, 8'h00, 8'd3, 1'b1};
    vecs[9]  = '{5'd6,  5'd0, 2'd1, 8'd2,  1'b1, 8'h07, 8'd3, 1'b1};
    vecs[10] = '{5'd8,  5'd0, 2'd2, 8'd16, 1'b1, 8'h00, 8'd3, 1'b1};
    vecs[11] = '{5'd9,  5'd0, 2'd2, 8'd3,  1'b1, 8'hA3, 8'd3, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",    32'(pkt_out_valid), 32'd0);
    chk("rst_pkt_out",  32'(pkt_out),       32'd0);
    chk("rst_busy",     32'(busy),          32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt),      32'd0);
    chk("rst_err_oor",  32'(err_oor),       32'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(pkt_in_ready), 32'd1);

    for (int unsigned i = 0; i < 64; i++) load(1'b0, 8'(i), 8'(i * 3 + 1));
    for (int unsigned i = 0; i < 16; i++) load(1'b1, 8'(i), 8'(8'hA0 + i));
    load(1'b0, 8'd5, 8'h2A);

    for (int unsigned i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Backpressure: three queued filter reads, response held under ready=0.
    load(1'b1, 8'd0, 8'd7);
    load(1'b1, 8'd1, 8'd8);
    load(1'b1, 8'd2, 8'd9);
    pkt_out_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      pkt_in = mkpkt(5'd4, 5'(MI), 2'd2, 8'(k));
      pkt_in_valid = 1'b1;
      chk($sformatf("bp_in_ready_%0d", k), 32'(pkt_in_ready), 32'd1);
      tick();
    end
    pkt_in_valid = 1'b0;
    pkt_in = '0;
    chk("bp_in_ready_full", 32'(pkt_in_ready), 32'd0);
    cyc = 0;
    while (!pkt_out_valid && cyc < 8) begin
      tick();
      cyc++;
    end
    first = pkt_out;
    chk("bp_first_valid", 32'(pkt_out_valid), 32'd1);
    chk("bp_first_pkt", 32'(first), 32'({5'(MI), 5'd4, 2'd2, 8'd7}));
    stable = 1'b1;
    ready_low = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      tick();
      if (!pkt_out_valid || pkt_out !== first) stable = 1'b0;
      if (pkt_in_ready !== 1'b0) ready_low = 1'b0;
    end
    chk("bp_held_stable", 32'(stable), 32'd1);
    chk("bp_in_ready_held_low", 32'(ready_low), 32'd1);
    pkt_out_ready = 1'b1;
    n = 0;
    for (int unsigned k = 0; k < 40 && n < 3; k++) begin
      if (pkt_out_valid) begin
        got[n] = pkt_out;
        n++;
      end
      tick();
    end
    chk("bp_resp_count", n, 32'd3);
    for (int unsigned k = 0; k < 3; k++) begin
      exp_pkt = {5'(MI), 5'd4, 2'd2, 8'(7 + k)};
      chk($sformatf("bp_resp_%0d", k), 32'(got[k]), 32'(exp_pkt));
    end
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Load collision: write ifmap[9] during the READ cycle of a read to ifmap[9].
    pkt_in = mkpkt(5'd2, 5'(MI), 2'd1, 8'd9);
    pkt_in_valid = 1'b1;
    tick();
    pkt_in_valid = 1'b0;
    pkt_in = '0;
    tick();
    ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 8'd9; ld_data = 8'h11;
    tick();
    ld_en = 1'b0;
    chk("col_valid_t2", 32'(pkt_out_valid), 32'd0);
    tick();
    chk("col_valid_t3", 32'(pkt_out_valid), 32'd0);
    tick();
    chk("col_valid_t4", 32'(pkt_out_valid), 32'd1);
    chk("col_pkt_out", 32'(pkt_out), 32'({5'(MI), 5'd2, 2'd1, 8'h11}));
    tick();
    chk("col_valid_done", 32'(pkt_out_valid), 32'd0);

    // Reset while a response is pending and one request is queued.
    pkt_out_ready = 1'b0;
    pkt_in = mkpkt(5'd10, 5'(MI), 2'd1, 8'd1);
    pkt_in_valid = 1'b1;
    tick();
    pkt_in = mkpkt(5'd10, 5'(MI), 2'd1, 8'd2);
    tick();
    pkt_in_valid = 1'b0;
    pkt_in = '0;
    cyc = 0;
    while (!pkt_out_valid && cyc < 8) begin
      tick();
      cyc++;
    end
    chk("rr_valid_before", 32'(pkt_out_valid), 32'd1);
    chk("rr_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rr_valid",    32'(pkt_out_valid), 32'd0);
    chk("rr_pkt_out",  32'(pkt_out),       32'd0);
    chk("rr_busy",     32'(busy),          32'd0);
    chk("rr_drop_cnt", 32'(drop_cnt),      32'd0);
    chk("rr_err_oor",  32'(err_oor),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    pkt_out_ready = 1'b1;
    tick();
    chk("rr_in_ready", 32'(pkt_in_ready), 32'd1);
    seen = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      if (pkt_out_valid) seen = 1'b1;
    end
    chk("rr_no_stale", 32'(seen), 32'd0);
    rv = '{5'd11, 5'd0, 2'd1, 8'd3, 1'b1, 8'd10, 8'd0, 1'b0};
    run_vec(rv, 99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_read_responder.md
Name: mem_read_responder

Overview:
- Memory-side endpoint of the PE load protocol.
- Accepts read-request packets from the router: type 1 = ifmap, type 2 = filter, with an 8-bit pointer in the data field.
- Reads the addressed word from the ifmap or filter store and returns a data packet to the requesting PE.
- One instance per memory node; stores are preloaded through a side load port before the PEs start.

Parameters:
- WIDTH, 5, node index width.
- VALID_DATA_WIDTH, 8, payload/data word width.
- DATA_WIDTH, 20, packet width; must equal 2*WIDTH+2+VALID_DATA_WIDTH.
- MEM_INDEX, 0, this node's router index.
- IFMAP_DEPTH, 64, ifmap store words; must be at most 256.
- FILTER_DEPTH, 16, filter store words; must be at most 256.
- FIFO_DEPTH, 2, request FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- pkt_in, in, DATA_WIDTH, request packet from the router.
- pkt_in_valid, in, 1, request present.
- pkt_in_ready, out, 1, FIFO not full.
- pkt_out, out, DATA_WIDTH, response packet to the router.
- pkt_out_valid, out, 1, response present.
- pkt_out_ready, in, 1, router accepts the response.
- ld_en, in, 1, store write strobe.
- ld_sel, in, 1, 0 = ifmap store, 1 = filter store.
- ld_addr, in, 8, store write address.
- ld_data, in, VALID_DATA_WIDTH, store write data.
- busy, out, 1, FIFO non-empty or FSM not in IDLE.
- drop_cnt, out, 8, saturating count of discarded requests.
- err_oor, out, 1, sticky flag: an out-of-range pointer was read.

Behaviour:
- Packet layout: [19:15] src, [14:10] dst, [9:8] type, [7:0] data.
- Handshake: a transfer occurs on a cycle where valid and ready are both high.
  - pkt_out and pkt_out_valid are registered and held stable until accepted.
  - pkt_in_ready = !fifo_full, combinational from FIFO state only.
- Admission filter, applied at acceptance:
  - Only packets with dst==MEM_INDEX and type in {1,2} are written to the FIFO.
  - All other accepted packets (wrong dst, type 0 or 3) are consumed and discarded; drop_cnt increments, saturating at 255.
- FSM states: IDLE, READ, RESP.
  - IDLE: if FIFO non-empty, pop head into a request register and go to READ.
  - READ: if ld_en is high this cycle, stay in READ; the load port has priority and the read stalls one cycle. Otherwise register the store output and go to RESP.
  - RESP: drive pkt_out = {MEM_INDEX, req.src, req.type, rdata} with pkt_out_valid=1. On pkt_out_ready go to IDLE; else hold.
- Store selection: type 1 reads the ifmap store, type 2 reads the filter store.
- Out of range: pointer >= the selected depth returns rdata=0 and sets err_oor. err_oor is cleared only by rst.
- Latency: request accepted at edge t with FSM idle and no load collision → pkt_out_valid high after edge t+3.
- Throughput: at most one response per 3 cycles.
- FIFO ordering: strict FIFO; responses leave in request order.
- Simultaneous push and pop on a full FIFO is not allowed, because ready is low when full. Simultaneous push and pop when not full is permitted.
- Load port: writes take effect at the edge where ld_en is high. A read in the following cycle sees the new data; no bypass is required within the same cycle.
- Reset (asynchronous, any time, including mid-response):
  - FSM goes to IDLE and the FIFO empties.
  - pkt_out_valid=0, pkt_out=0, drop_cnt=0, err_oor=0, busy=0.
  - Store contents are not cleared.
  - pkt_in_ready=1 once reset is deasserted.
- Width rule: returned data is the raw stored VALID_DATA_WIDTH word; no arithmetic is performed on it.

Test Plan:
- Basic read: load ifmap[5]=0x2A; send {src=3, dst=MEM_INDEX, type=1, data=5}; pkt_out_ready=1 → exactly 3 cycles later pkt_out={src=MEM_INDEX, dst=3, type=1, data=0x2A}, valid for 1 cycle.
- Back-to-back requests with backpressure:
  - Stimulus: filter[0..2]=7,8,9; send 3 type-2 reads from src=4 back-to-back; hold pkt_out_ready=0 for 10 cycles.
  - Required: pkt_in_ready drops after 2 queued plus 1 in the FSM; the first response is held stable throughout; releasing ready yields 7, 8, 9 in order.
- Drop path: send dst=MEM_INDEX+1, then type=3, then type=0 → no responses, drop_cnt=3, busy stays 0.
- Out of range: ifmap read with pointer=IFMAP_DEPTH → response data=0, err_oor=1 and remains 1 after further good reads.
- Load collision: hold ld_en=1 writing ifmap[9]=0x11 during the READ cycle of a read to ifmap[9] → response is delayed 1 cycle and returns 0x11.
- Reset mid-RESP: assert rst while pkt_out_valid=1 and the FIFO holds 1 entry → all outputs are 0 immediately; after release, a new read returns correct data and no stale response appears.
